// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: walks one LCD frame in raster order. It steps the external
// X/Y address counters through x_enable/y_enable and keeps matching shadow
// positions, so the counters always finish a frame (or an abort) at (0,0).
module frame_scan_ctrl #(
    parameter logic [8:0] X_MAX = 9'd239,
    parameter logic [8:0] Y_MAX = 9'd319
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       abort,
    input  logic       pixel_ready,
    output logic       pixel_valid,
    output logic       x_enable,
    output logic       y_enable,
    output logic [8:0] x_pos,
    output logic [8:0] y_pos,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REWIND = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   step;
    logic   x_last;
    logic   at_end;

    assign x_last = (x_pos == X_MAX);
    assign at_end = x_last && (y_pos == Y_MAX);

    // The enables are combinational, so the external counters and the shadow
    // positions move on the same edge.
    assign x_enable = step;
    assign y_enable = step & x_last;
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, handshake and step generation
    always_comb begin
        state_nxt   = state;
        pixel_valid = 1'b0;
        step        = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = SCAN;
            end
            SCAN: begin
                pixel_valid = 1'b1;
                step        = pixel_ready;
                // A transfer of the last pixel completes the frame, even if
                // abort arrives in the same cycle.
                if (pixel_ready && at_end) state_nxt = DONE;
                else if (abort)            state_nxt = REWIND;
            end
            REWIND: begin
                // Free-run the counters forward until they wrap to (0,0).
                step = 1'b1;
                if (at_end) state_nxt = IDLE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow positions, wrapping like the external counters (>= MAX -> 0)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_pos <= '0;
            y_pos <= '0;
        end else if (step) begin
            if (x_pos >= X_MAX) begin
                x_pos <= '0;
                if (y_pos >= Y_MAX) y_pos <= '0;
                else                y_pos <= y_pos + 9'd1;
            end else begin
                x_pos <= x_pos + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Directed bench for frame_scan_ctrl on a 4x3 frame, with external
// wrap-at-MAX address counters driven by x_enable/y_enable.
module tb_frame_scan_ctrl;

    localparam int XM = 3;
    localparam int YM = 2;
    localparam int NPIX = (XM + 1) * (YM + 1);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       abort = 1'b0;
    logic       pixel_ready = 1'b0;
    logic       pixel_valid, x_enable, y_enable, busy, frame_done;
    logic [8:0] x_pos, y_pos;
    logic [8:0] xcnt, ycnt;

    int total = 0;
    int bad   = 0;
    int ei    = 0;   // expected raster index of the current pixel

    frame_scan_ctrl #(.X_MAX(9'd3), .Y_MAX(9'd2)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .abort       (abort),
        .pixel_ready (pixel_ready),
        .pixel_valid (pixel_valid),
        .x_enable    (x_enable),
        .y_enable    (y_enable),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    // External address counters sharing the controller's reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            xcnt <= '0;
            ycnt <= '0;
        end else begin
            if (x_enable) xcnt <= (xcnt >= 9'(XM)) ? 9'd0 : xcnt + 9'd1;
            if (y_enable) ycnt <= (ycnt >= 9'(YM)) ? 9'd0 : ycnt + 9'd1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse (or hold) frame_start from IDLE; returns one cycle later in SCAN.
    task automatic start_frame(input bit hold);
        frame_start = 1'b1;
        tick();
        if (!hold) frame_start = 1'b0;
        ei = 0;
    endtask

    // Perform n transfers; mode 0 = ready always, mode 1 = ready 1,0,0,1,0,0...
    task automatic xfers(input int n, input int mode);
        int done = 0;
        int c = 0;
        while (done < n && c < 500) begin
            pixel_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            #1;
            chk("valid", pixel_valid, 1);
            chk("busy", busy, 1);
            chk("x", x_pos, ei % (XM + 1));
            chk("y", y_pos, ei / (XM + 1));
            chk("xcnt", xcnt, ei % (XM + 1));
            chk("ycnt", ycnt, ei / (XM + 1));
            chk("xen", x_enable, pixel_ready);
            chk("yen", y_enable, pixel_ready && (ei % (XM + 1) == XM));
            if (pixel_ready) begin
                ei++;
                done++;
            end
            tick();
            c++;
        end
        if (done < n) chk("xfer_timeout", done, n);
    endtask

    task automatic chk_done_then_idle();
        chk("done_pulse", frame_done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", pixel_valid, 0);
        chk("done_x", x_pos, 0);
        chk("done_y", y_pos, 0);
        chk("done_xcnt", xcnt, 0);
        chk("done_ycnt", ycnt, 0);
        tick();
        chk("post_done", frame_done, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        int c;
        // Reset state
        #12;
        chk("rst_valid", pixel_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        reset = 1'b0;
        tick();

        // 1: full frame, ready ignored in IDLE, 12 transfers then DONE
        pixel_ready = 1'b1;
        #1;
        chk("idle_xen", x_enable, 0);
        start_frame(1'b0);
        xfers(NPIX, 0);
        chk_done_then_idle();

        // 2: stalls hold position, still 12 transfers
        start_frame(1'b0);
        xfers(NPIX, 1);
        pixel_ready = 1'b0;
        chk_done_then_idle();

        // 3: abort at (1,1) with no transfer -> rewind from index 5 through 11
        start_frame(1'b0);
        xfers(5, 0);
        pixel_ready = 1'b0;
        abort = 1'b1;
        #1;
        chk("ab_x", x_pos, 1);
        chk("ab_y", y_pos, 1);
        chk("ab_xen", x_enable, 0);
        tick();
        abort = 1'b0;
        pixel_ready = 1'b1;   // ignored outside SCAN
        c = 0;
        while (busy && c < 50) begin
            chk("rw_valid", pixel_valid, 0);
            chk("rw_done", frame_done, 0);
            chk("rw_xen", x_enable, 1);
            tick();
            c++;
        end
        chk("rw_cycles", c, NPIX - 5);
        chk("rw_x", x_pos, 0);
        chk("rw_y", y_pos, 0);
        chk("rw_xcnt", xcnt, 0);
        chk("rw_ycnt", ycnt, 0);
        chk("rw_nodone", frame_done, 0);

        // 4: abort together with the last transfer completes the frame
        start_frame(1'b0);
        xfers(NPIX - 1, 0);
        abort = 1'b1;
        #1;
        chk("abl_x", x_pos, XM);
        chk("abl_y", y_pos, YM);
        chk("abl_xen", x_enable, 1);
        chk("abl_yen", y_enable, 1);
        tick();
        abort = 1'b0;
        pixel_ready = 1'b0;
        chk_done_then_idle();

        // 5: frame_start held high; restart only from IDLE after DONE
        start_frame(1'b1);
        xfers(NPIX, 0);
        chk("hold_done", frame_done, 1);
        tick();
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_valid", pixel_valid, 0);
        tick();
        frame_start = 1'b0;
        chk("hold_restart", pixel_valid, 1);
        ei = 0;
        xfers(NPIX, 0);
        chk_done_then_idle();

        // 6: async reset at (2,1) mid-SCAN
        start_frame(1'b0);
        xfers(6, 0);
        pixel_ready = 1'b0;
        #1;
        chk("pre_rst_x", x_pos, 2);
        chk("pre_rst_y", y_pos, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", pixel_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_x", x_pos, 0);
        chk("arst_y", y_pos, 0);
        chk("arst_xcnt", xcnt, 0);
        chk("arst_ycnt", ycnt, 0);
        tick();
        reset = 1'b0;
        tick();
        start_frame(1'b0);
        xfers(NPIX, 0);
        pixel_ready = 1'b0;
        chk_done_then_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
